// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//
// Purpose:
//   Receives a standard I2S stream (one-bit-delayed word select, MSB first)
//   and presents each completed stereo frame as {left, right} on Rx with a
//   Valid/Ready handshake. SCLK, LRCLK and SD are asynchronous to Clock and are
//   oversampled (Clock must run at least 4x SCLK).
//
// Ports:
//   Clock     in   system clock, rising edge
//   nReset    in   asynchronous active-low reset
//   onOff     in   receive enable; low forces idle and drops partial frames
//   SCLK      in   I2S bit clock (asynchronous)
//   LRCLK     in   I2S word select, 0 = left slot, 1 = right slot
//   SD        in   I2S serial data, MSB first
//   Rx        out  last completed frame {left, right}, left in upper WIDTH bits
//   Valid     out  Rx holds a frame not yet accepted by the consumer
//   Ready     in   consumer accepts Rx in a cycle with Valid & Ready
//   Overrun   out  sticky: a completed frame replaced an unaccepted one
//   FrameErr  out  one-cycle pulse: a slot length differed from WIDTH
// -----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               onOff,
  input  logic               SCLK,
  input  logic               LRCLK,
  input  logic               SD,
  output logic [2*WIDTH-1:0] Rx,
  output logic               Valid,
  input  logic               Ready,
  output logic               Overrun,
  output logic               FrameErr
);

  // Slot counter must be able to hold 2*WIDTH (its saturation value).
  localparam int CNT_W = $clog2(2 * WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * WIDTH);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(WIDTH);

  localparam logic [1:0] SYNC_WAIT = 2'd0;
  localparam logic [1:0] RX_LEFT   = 2'd1;
  localparam logic [1:0] RX_RIGHT  = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronizers and SCLK edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync_r;
  logic [1:0] lr_sync_r;
  logic [1:0] sd_sync_r;
  logic       sclk_prev_r;

  // Two-flop synchronizers for all three I2S pins plus SCLK history flop.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_r <= 2'b00;
      lr_sync_r   <= 2'b00;
      sd_sync_r   <= 2'b00;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], SCLK};
      lr_sync_r   <= {lr_sync_r[0], LRCLK};
      sd_sync_r   <= {sd_sync_r[0], SD};
      sclk_prev_r <= sclk_sync_r[1];
    end
  end

  logic sclk_rise_s;
  logic lr_s;
  logic sd_s;

  // LRCLK and SD travel through the same synchronizer depth as SCLK, so the
  // values seen in the rise cycle are the ones present at the pin edge.
  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
  assign lr_s        = lr_sync_r[1];
  assign sd_s        = sd_sync_r[1];

  // ---------------------------------------------------------------------------
  // Receive state
  // ---------------------------------------------------------------------------
  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [WIDTH-2:0]   shift_r;     // previous WIDTH-1 bits; current bit completes a word
  logic [CNT_W-1:0]   slot_cnt_r;  // rises since the last LRCLK change
  logic               lr_prev_r;   // LRCLK level sampled on the previous rise
  logic [WIDTH-1:0]   left_r;
  logic [2*WIDTH-1:0] frame_r;
  logic               done_r;

  logic             lr_change_s;
  logic             lr_fall_s;
  logic             lr_rise_s;
  logic             slot_ok_s;
  logic [WIDTH-1:0] word_s;
  logic             latch_left_s;
  logic             frame_done_s;
  logic             frame_err_s;

  // The rise that first shows a new LRCLK level carries the LSB of the slot
  // that just ended, so the word is the stored bits plus the current bit and
  // the count checked is the one from before the restart.
  assign lr_change_s = lr_s ^ lr_prev_r;
  assign lr_fall_s   = lr_change_s & ~lr_s;
  assign lr_rise_s   = lr_change_s & lr_s;
  assign slot_ok_s   = (slot_cnt_r == SLOT_LEN);
  assign word_s      = {shift_r, sd_s};

  // Next-state decode for the slot framing state machine.
  always_comb begin
    state_nxt_s  = state_r;
    latch_left_s = 1'b0;
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    if (!onOff) begin
      state_nxt_s = SYNC_WAIT;
    end else if (sclk_rise_s) begin
      case (state_r)
        SYNC_WAIT: begin
          if (lr_fall_s) begin
            state_nxt_s = RX_LEFT;
          end else begin
            state_nxt_s = SYNC_WAIT;
          end
        end
        RX_LEFT: begin
          if (lr_rise_s) begin
            if (slot_ok_s) begin
              latch_left_s = 1'b1;
              state_nxt_s  = RX_RIGHT;
            end else begin
              frame_err_s = 1'b1;
              state_nxt_s = SYNC_WAIT;
            end
          end else begin
            state_nxt_s = RX_LEFT;
          end
        end
        RX_RIGHT: begin
          if (lr_fall_s) begin
            if (slot_ok_s) begin
              frame_done_s = 1'b1;
              state_nxt_s  = RX_LEFT;
            end else begin
              frame_err_s = 1'b1;
              state_nxt_s = SYNC_WAIT;
            end
          end else begin
            state_nxt_s = RX_RIGHT;
          end
        end
        default: begin
          state_nxt_s = SYNC_WAIT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Framing state, shift register, slot counter and assembled frame.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r    <= SYNC_WAIT;
      shift_r    <= '0;
      slot_cnt_r <= '0;
      lr_prev_r  <= 1'b0;
      left_r     <= '0;
      frame_r    <= '0;
      done_r     <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      done_r   <= frame_done_s;
      FrameErr <= frame_err_s;
      // LRCLK history keeps tracking while disabled so that re-enabling in
      // the middle of a right slot still catches the next falling change.
      if (sclk_rise_s) begin
        lr_prev_r <= lr_s;
      end
      if (!onOff) begin
        shift_r    <= '0;
        slot_cnt_r <= '0;
        left_r     <= '0;
      end else if (sclk_rise_s) begin
        shift_r <= word_s[WIDTH-2:0];
        if (lr_change_s) begin
          slot_cnt_r <= CNT_ONE;
        end else if (slot_cnt_r != CNT_MAX) begin
          slot_cnt_r <= slot_cnt_r + CNT_ONE;
        end
        if (latch_left_s) begin
          left_r <= word_s;
        end
        if (frame_done_s) begin
          frame_r <= {left_r, word_s};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------

  // A new frame always wins over a same-cycle acceptance; only a frame that
  // lands on an unaccepted one flags Overrun.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Rx      <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else if (done_r && onOff) begin
      Rx    <= frame_r;
      Valid <= 1'b1;
      if (Valid && !Ready) begin
        Overrun <= 1'b1;
      end
    end else if (Valid && Ready) begin
      Valid <= 1'b0;
    end
  end

endmodule
